// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART constants and FIFO operation types
// Line constants are shared with the uartTX/uartRX blocks.
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int CLK_FREQ     = 50_000_000;
   localparam int BAUD         = 9600;
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   localparam int FIFO_DEPTH   = 16;
   localparam int FIFO_ADDR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e op_of(input logic push, input logic pop);
      return fifo_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write / uartTX handshake bundle for uart_tx_fifo
// Optional almost_full signal guarded by UART_TX_FIFO_ALMOST_FULL_EN.
interface uart_tx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              clr_ovf;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   logic              almost_full;
`endif

   modport slave (
      input  wr_en, wr_data, clr_ovf, tx_ready,
      output full, empty, count, overflow, tx_valid, tx_data
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      , output almost_full
`endif
   );

   modport master (
      output wr_en, wr_data, clr_ovf, tx_ready,
      input  full, empty, count, overflow, tx_valid, tx_data
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      , input almost_full
`endif
   );

endinterface

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - simple dual-port register array, sync write, async read
// Cleared on reset so the read port shows zero until first written.
module uart_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead byte FIFO feeding uartTX, sticky overflow flag
// Optional almost_full output and AF_LEVEL parameter under UART_TX_FIFO_ALMOST_FULL_EN.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int DEPTH    = FIFO_DEPTH,
   parameter int ADDR_W   = FIFO_ADDR_W
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_fifo_if.slave   bus
);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              overflow_q, overflow_d;
   logic              push, pop;
   fifo_op_e          op;

   // A full buffer still accepts a write when the head leaves on the same edge.
   always_comb begin
      pop        = !empty_q && bus.tx_ready;
      push       = bus.wr_en && (!full_q || pop);
      op         = op_of(push, pop);
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      unique case (op)
         OP_PUSH: count_d = count_q + 1'b1;
         OP_POP:  count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      empty_d    = (count_d == '0);
      full_d     = (count_d == (ADDR_W+1)'(DEPTH));
      overflow_d = overflow_q;
      if (bus.wr_en && !push) begin
         overflow_d = 1'b1;
      end else if (bus.clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (bus.tx_data)
   );

   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.tx_valid = !empty_q;

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   logic almost_full_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= (count_d >= (ADDR_W+1)'(AF_LEVEL));
      end
   end

   assign bus.almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue model
// Exercises almost_full as well when UART_TX_FIFO_ALMOST_FULL_EN is defined.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   typedef struct {
      logic       we;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      int         cnt;
      logic       emp;
      logic       ful;
      logic       vld;
      logic [7:0] dat;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   uart_tx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         errors = 0;
   int         checks = 0;
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic [7:0] last_byte;
   vec_t       tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a byte queue plus a sticky flag, updated by the transfer rules.
   task automatic step(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
      bit pop, push;
      bus.wr_en    = we;
      bus.wr_data  = d;
      bus.tx_ready = rdy;
      bus.clr_ovf  = clr;
      pop  = (mq.size() > 0) && rdy;
      push = we && ((mq.size() < DEPTH) || pop);
      if (we && !push) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      @(posedge clk);
      #1;
      bus.wr_en    = 1'b0;
      bus.tx_ready = 1'b0;
      bus.clr_ovf  = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 32'(mq.size()));
      chk({tag, "_empty"}, 32'(bus.empty), 32'(mq.size() == 0));
      chk({tag, "_full"},  32'(bus.full),  32'(mq.size() == DEPTH));
      chk({tag, "_valid"}, 32'(bus.tx_valid), 32'(mq.size() != 0));
      chk({tag, "_ovf"},   32'(bus.overflow), 32'(m_ovf));
      if (mq.size() != 0) chk({tag, "_data"}, 32'(bus.tx_data), 32'(mq[0]));
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      chk({tag, "_af"}, 32'(bus.almost_full), 32'(mq.size() >= DEPTH - 2));
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_data  = '0;
      bus.tx_ready = 1'b0;
      bus.clr_ovf  = 1'b0;
      tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
      tbl[1] = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0};
      tbl[3] = '{1'b1, 8'h12, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[6] = '{1'b1, 8'h9C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h9C, 1'b0};

      @(posedge clk);
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      chk("rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_ovf",   32'(bus.overflow), 32'd0);
      chk("rst_data",  32'(bus.tx_data),  32'd0);
      do_reset();

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].we, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
         chk($sformatf("vec%0d_full", i),  32'(bus.full),  32'(tbl[i].ful));
         chk($sformatf("vec%0d_valid", i), 32'(bus.tx_valid), 32'(tbl[i].vld));
         chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(tbl[i].ovf));
         if (tbl[i].vld) chk($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(tbl[i].dat));
      end

      // Fill to full, drop one, drain in order.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'd16);
      chk("fill_full",  32'(bus.full),  32'd1);
      chk("fill_ovf",   32'(bus.overflow), 32'd0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("drop_count", 32'(bus.count), 32'd16);
      chk("drop_ovf",   32'(bus.overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d_data", i), 32'(bus.tx_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("drain_valid", 32'(bus.tx_valid), 32'd0);
      chk("drain_ovf",   32'(bus.overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(bus.overflow), 32'd0);

      // Set and clear in the same cycle: set wins.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("setclr_ovf", 32'(bus.overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr2_ovf", 32'(bus.overflow), 32'd0);

      // Full with simultaneous push and pop.
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("pp_count", 32'(bus.count), 32'd16);
      chk("pp_ovf",   32'(bus.overflow), 32'd0);
      chk("pp_data",  32'(bus.tx_data),  32'h11);
      last_byte = 8'h00;
      for (int i = 0; i < 16; i++) begin
         last_byte = bus.tx_data;
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("pp_last", 32'(last_byte), 32'h77);
      chk("pp_empty", 32'(bus.empty), 32'd1);

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      for (int i = 0; i < 14; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("af_at14", 32'(bus.almost_full), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("af_at13", 32'(bus.almost_full), 32'd0);
      do_reset();
`endif

      // Randomized traffic: write-heavy, balanced, then read-heavy phases.
      for (int i = 0; i < 1500; i++) begin
         int wp;
         wp = (i < 500) ? 80 : (i < 1000) ? 50 : 25;
         step(($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < 45),
              ($urandom_range(99) < 8));
         check_model($sformatf("rnd%0d", i));
      end

      // Asynchronous reset mid-operation with count=5 and overflow set.
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(bus.count), 32'd5);
      chk("pre_rst_ovf",   32'(bus.overflow), 32'd1);
      #4;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count), 32'd0);
      chk("arst_empty", 32'(bus.empty), 32'd1);
      chk("arst_valid", 32'(bus.tx_valid), 32'd0);
      chk("arst_ovf",   32'(bus.overflow), 32'd0);
      chk("arst_data",  32'(bus.tx_data),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer that sits directly upstream of the uartTX transmitter.
- Accepts bursts of bytes from the host or register side and holds them in a circular buffer.
- Presents the head byte to uartTX through the valid/ready handshake, one byte per transmitted frame.
- Decouples host write rate from the 9600-baud line rate.

Parameters:
- DATA_W, 8: byte width; must match uartTX pi_data.
- DEPTH, 16: number of entries; power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  host write strobe, one byte per cycle
- wr_data  input  DATA_W  host write byte
- full  output  1  buffer holds DEPTH bytes
- empty  output  1  buffer holds 0 bytes
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was dropped
- clr_ovf  input  1  clears overflow
- tx_valid  output  1  drives uartTX valid
- tx_data  output  DATA_W  drives uartTX pi_data
- tx_ready  input  1  from uartTX ready; high when the transmitter can accept a byte

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low on rst_n.
  - While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, tx_valid=0, tx_data=0.
  - Reset mid-frame discards all contents. uartTX is reset by the same rst_n.
- Storage:
  - DEPTH x DATA_W register array.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked explicitly.
  - empty = (count==0); full = (count==DEPTH). Both are registered, derived from the next-state count.
- Output (show-ahead):
  - tx_data always shows mem[rd_ptr]; tx_valid = !empty.
  - Write to an empty buffer at edge N: tx_valid=1 and tx_data=byte after edge N, i.e. 1-cycle latency.
- Pop:
  - Occurs when tx_valid && tx_ready at a rising edge.
  - rd_ptr increments and count decrements.
  - tx_data updates to the next entry on the same edge.
- Push:
  - Occurs when wr_en && (!full || pop).
  - Writes mem[wr_ptr] and increments wr_ptr.
- Simultaneous push and pop: count unchanged.
  - When full, a write coincident with a pop is accepted.
  - When empty, no pop is possible (tx_valid=0), so a push alone occurs.
- Overflow:
  - wr_en while full and no pop: the byte is dropped and pointers are untouched.
  - overflow is set on the next edge and holds until clr_ovf=1.
  - If set and clear occur in the same cycle, set wins.
- tx_ready must not depend combinationally on tx_valid.
- tx_valid may deassert only after a pop empties the buffer. A byte presented is never withdrawn.
- A DEPTH=16 buffer drains in 16 frames, approximately 16 x 1.0416 ms at 9600 8N1.

Optional Feature:
- Macro: UART_TX_FIFO_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2).
  - Adds output almost_full (1 bit, registered): high when count >= AF_LEVEL, reset value 0.
  - The host uses it for flow control.
- When undefined: the port and parameter are absent, and no logic is generated.

Decomposition:
- Shared include file uart_defs.vh holds:
  - UART_DATA_W=8
  - CLK_FREQ=50_000_000
  - BAUD=9600
  - CLKS_PER_BIT=5208
- This file is shared with uartTX and uartRX.
- One natural sub-module: uart_fifo_ram.
  - Simple dual-port array: synchronous write port, asynchronous read at rd_ptr.
  - Reusable for a later RX-side buffer after uartRX po_data/po_flag.
- Pointer and count logic stays in uart_tx_fifo.

Test Plan:
- Reset check: assert rst_n=0 mid-operation with count=5 -> count=0, empty=1, tx_valid=0, overflow=0 immediately (asynchronous).
- Single byte: write 8'h55 with tx_ready=0 -> tx_valid=1, tx_data=8'h55 one cycle later. Raise tx_ready for 1 cycle -> empty=1 next edge.
- Fill to full: write 8'h00..8'h0F with tx_ready=0 -> full=1, count=16. 17th write 8'hAA -> dropped, overflow=1. Drain -> sequence 8'h00..8'h0F, no 8'hAA. clr_ovf -> overflow=0.
- Full plus simultaneous push/pop: wr_en=1 with 8'h77 and tx_ready=1 -> count stays 16, overflow stays 0, 8'h77 emerges last.
- End-to-end with uartTX: write 8'h55, 8'hA3 -> tx line shows two 8N1 frames of 104160 ns/bit, LSB first. tx_valid=0 after the second pop.
- With UART_TX_FIFO_ALMOST_FULL_EN defined: write 14 bytes -> almost_full=1 at count=14 and 0 at count=13 after one pop.
